// File: rtl/sta_tile_scheduler_pkg.sv
// Shared types, sizes and small helpers for the STA tile scheduler.
package sta_tile_scheduler_pkg;

  localparam int OC_MAX_N        = 512;
  localparam int NUM_CH          = 64;
  localparam int CH_BITS         = $clog2(NUM_CH + 1);
  localparam int SA_N            = 4;
  localparam int SA_VECTOR_WIDTH = 4;
  localparam int K_MAX           = 1024;
  localparam int DRAIN_CYCLES    = 8;

  localparam int COORD_W     = $clog2(OC_MAX_N + 1);
  localparam int KLEN_W      = $clog2(K_MAX + 1);
  localparam int KIDX_W      = $clog2(K_MAX / SA_VECTOR_WIDTH);
  localparam int SKEW_DEPTH  = 2 * SA_N - 1;
  // DRAIN is entered right after the last read; it covers the skew of the
  // last load_sum pulse plus the pipeline drain that follows it.
  localparam int DRAIN_TOTAL = SKEW_DEPTH + DRAIN_CYCLES;
  localparam int DCNT_W      = $clog2(DRAIN_TOTAL + 1);

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CH_BITS-1:0] ch_t;
  typedef logic [KIDX_W-1:0]  kidx_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } sched_state_e;

  // Index of the last vector in a tile: ceil(klen / SA_VECTOR_WIDTH) - 1.
  // Only meaningful for klen != 0.
  function automatic kidx_t kvecs_last(input logic [KLEN_W-1:0] klen);
    logic [KLEN_W:0] v;
    v = ({1'b0, klen} + (KLEN_W + 1)'(SA_VECTOR_WIDTH - 1)) >> $clog2(SA_VECTOR_WIDTH);
    v = v - (KLEN_W + 1)'(1);
    return v[KIDX_W-1:0];
  endfunction

  // True when stepping a tile base by SA_N would leave the matrix.
  function automatic logic pos_wraps(input coord_t pos, input coord_t mat);
    return ({1'b0, pos} + (COORD_W + 1)'(SA_N)) >= {1'b0, mat};
  endfunction

  // Next tile base, saturating at OC_MAX_N.
  function automatic coord_t pos_step(input coord_t pos);
    logic [COORD_W:0] v;
    v = {1'b0, pos} + (COORD_W + 1)'(SA_N);
    if (v > (COORD_W + 1)'(OC_MAX_N)) v = (COORD_W + 1)'(OC_MAX_N);
    return v[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/sta_tile_scheduler_wavefront_skew.sv
// Diagonal wavefront generator: PE(i,j) sees a token i+j cycles after it
// enters stage 0, giving the skewed load_bias / load_sum masks.
module wavefront_skew
  import sta_tile_scheduler_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_stall,
  input  logic                 i_bias_token,
  input  logic                 i_sum_token,
  output logic [SA_N*SA_N-1:0] o_load_bias_mask,
  output logic [SA_N*SA_N-1:0] o_load_sum_mask
);

  logic [SKEW_DEPTH-1:0] r_bias_sr;
  logic [SKEW_DEPTH-1:0] r_sum_sr;

  // Shift both token lines one stage per unstalled cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bias_sr <= '0;
      r_sum_sr  <= '0;
    end else if (!i_stall) begin
      r_bias_sr <= {r_bias_sr[SKEW_DEPTH-2:0], i_bias_token};
      r_sum_sr  <= {r_sum_sr[SKEW_DEPTH-2:0],  i_sum_token};
    end
  end

  // Tap stage i+j for PE(i,j); pulses are held back while stalled.
  always_comb begin
    o_load_bias_mask = '0;
    o_load_sum_mask  = '0;
    for (int i = 0; i < SA_N; i++) begin
      for (int j = 0; j < SA_N; j++) begin
        o_load_bias_mask[i*SA_N+j] = r_bias_sr[i+j] & ~i_stall;
        o_load_sum_mask[i*SA_N+j]  = r_sum_sr[i+j]  & ~i_stall;
      end
    end
  end

endmodule

// File: rtl/sta_tile_scheduler.sv
// Sweeps one layer over SA_N x SA_N output tiles, issuing buffer reads,
// controller tile starts and skewed per-PE bias/sum load masks.
module sta_tile_scheduler
  import sta_tile_scheduler_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 start,
  input  logic [COORD_W-1:0]   cfg_mat_size,
  input  logic [CH_BITS-1:0]   cfg_num_ch,
  input  logic [KLEN_W-1:0]    cfg_k_len,
  output logic                 rd_en,
  output logic [KIDX_W-1:0]    rd_k,
  output logic [COORD_W-1:0]   rd_row,
  output logic [COORD_W-1:0]   rd_col,
  output logic [CH_BITS-1:0]   rd_channel,
  output logic                 controller_input_valid,
  output logic [COORD_W-1:0]   controller_mat_size,
  output logic [COORD_W-1:0]   controller_pos_row,
  output logic [COORD_W-1:0]   controller_pos_col,
  output logic [CH_BITS-1:0]   controller_channel,
  output logic [SA_N*SA_N-1:0] load_bias_mask,
  output logic [SA_N*SA_N-1:0] load_sum_mask,
  output logic                 busy,
  output logic                 done
);

  sched_state_e      r_state, w_state_nxt;
  coord_t            r_mat, r_row, r_col, r_ctrl_row, r_ctrl_col;
  ch_t               r_nch, r_ch, r_ctrl_ch;
  kidx_t             r_klast, r_k;
  logic [DCNT_W-1:0] r_dcnt;
  logic              r_vld_p1, r_sum_tok_p1, r_done;

  logic w_cfg_zero, w_accept, w_issue, w_first_k, w_k_wrap;
  logic w_col_wrap, w_row_wrap, w_ch_last, w_last_issue, w_drain_end, w_done_set;

  assign w_cfg_zero   = (cfg_mat_size == '0) || (cfg_num_ch == '0) || (cfg_k_len == '0);
  assign w_accept     = (r_state == S_IDLE) && start && !stall;
  assign w_issue      = (r_state == S_RUN) && !stall;
  assign w_first_k    = (r_k == '0);
  assign w_k_wrap     = (r_k == r_klast);
  assign w_col_wrap   = pos_wraps(r_col, r_mat);
  assign w_row_wrap   = pos_wraps(r_row, r_mat);
  assign w_ch_last    = (r_ch == r_nch - ch_t'(1));
  assign w_last_issue = w_k_wrap && w_col_wrap && w_row_wrap && w_ch_last;
  assign w_drain_end  = (r_state == S_DRAIN) && !stall &&
                        (r_dcnt == DCNT_W'(DRAIN_TOTAL - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; transitions only happen on unstalled cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_done_set  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_cfg_zero) w_done_set  = 1'b1;
          else            w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_issue && w_last_issue) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_drain_end) begin
          w_state_nxt = S_IDLE;
          w_done_set  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Configuration latch, tile/k counters, controller tile info, drain count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mat <= '0; r_nch <= '0; r_klast <= '0;
      r_k <= '0; r_row <= '0; r_col <= '0; r_ch <= '0;
      r_ctrl_row <= '0; r_ctrl_col <= '0; r_ctrl_ch <= '0;
      r_dcnt <= '0; r_vld_p1 <= 1'b0; r_sum_tok_p1 <= 1'b0;
    end else if (!stall) begin
      // Stage p1: tile start and end-of-reduction tokens, one cycle after the read.
      r_vld_p1     <= w_issue && w_first_k;
      r_sum_tok_p1 <= w_issue && w_k_wrap;
      if (w_accept) begin
        r_mat   <= cfg_mat_size;
        r_nch   <= cfg_num_ch;
        r_klast <= w_cfg_zero ? '0 : kvecs_last(cfg_k_len);
        r_k     <= '0;
        r_row   <= '0;
        r_col   <= '0;
        r_ch    <= '0;
        r_dcnt  <= '0;
      end
      if (w_issue) begin
        if (w_k_wrap) begin
          r_k <= '0;
          if (w_col_wrap) begin
            r_col <= '0;
            if (w_row_wrap) begin
              r_row <= '0;
              if (!w_ch_last) r_ch <= r_ch + ch_t'(1);
            end else begin
              r_row <= pos_step(r_row);
            end
          end else begin
            r_col <= pos_step(r_col);
          end
        end else begin
          r_k <= r_k + kidx_t'(1);
        end
        if (w_first_k) begin
          r_ctrl_row <= r_row;
          r_ctrl_col <= r_col;
          r_ctrl_ch  <= r_ch;
        end
      end
      if (r_state == S_DRAIN) r_dcnt <= r_dcnt + DCNT_W'(1);
    end
  end

  // One-cycle layer-complete pulse.
  always_ff @(posedge clk) begin
    if (reset) r_done <= 1'b0;
    else       r_done <= w_done_set;
  end

  wavefront_skew u_skew (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_stall          (stall),
    .i_bias_token     (w_issue && w_first_k),
    .i_sum_token      (r_sum_tok_p1),
    .o_load_bias_mask (load_bias_mask),
    .o_load_sum_mask  (load_sum_mask)
  );

  assign rd_en                  = w_issue;
  assign rd_k                   = r_k;
  assign rd_row                 = r_row;
  assign rd_col                 = r_col;
  assign rd_channel             = r_ch;
  assign controller_input_valid = r_vld_p1 && !stall;
  assign controller_mat_size    = r_mat;
  assign controller_pos_row     = r_ctrl_row;
  assign controller_pos_col     = r_ctrl_col;
  assign controller_channel     = r_ctrl_ch;
  assign busy                   = (r_state != S_IDLE);
  assign done                   = r_done;

endmodule

// File: tb/tb_sta_tile_scheduler.sv
// Scoreboard bench for sta_tile_scheduler: directed layers push expected
// reads, tile starts, mask pulses and done cycles; a monitor pops and compares.
module tb_sta_tile_scheduler;
  import sta_tile_scheduler_pkg::*;

  typedef struct {
    int cyc;
    int a;
    int b;
    int c;
    int d;
  } ev_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 stall = 1'b0;
  logic                 start = 1'b0;
  logic [COORD_W-1:0]   cfg_mat_size = '0;
  logic [CH_BITS-1:0]   cfg_num_ch = '0;
  logic [KLEN_W-1:0]    cfg_k_len = '0;
  logic                 rd_en;
  logic [KIDX_W-1:0]    rd_k;
  logic [COORD_W-1:0]   rd_row, rd_col;
  logic [CH_BITS-1:0]   rd_channel;
  logic                 controller_input_valid;
  logic [COORD_W-1:0]   controller_mat_size, controller_pos_row, controller_pos_col;
  logic [CH_BITS-1:0]   controller_channel;
  logic [SA_N*SA_N-1:0] load_bias_mask, load_sum_mask;
  logic                 busy, done;

  sta_tile_scheduler dut (
    .clk                    (clk),
    .reset                  (reset),
    .stall                  (stall),
    .start                  (start),
    .cfg_mat_size           (cfg_mat_size),
    .cfg_num_ch             (cfg_num_ch),
    .cfg_k_len              (cfg_k_len),
    .rd_en                  (rd_en),
    .rd_k                   (rd_k),
    .rd_row                 (rd_row),
    .rd_col                 (rd_col),
    .rd_channel             (rd_channel),
    .controller_input_valid (controller_input_valid),
    .controller_mat_size    (controller_mat_size),
    .controller_pos_row     (controller_pos_row),
    .controller_pos_col     (controller_pos_col),
    .controller_channel     (controller_channel),
    .load_bias_mask         (load_bias_mask),
    .load_sum_mask          (load_sum_mask),
    .busy                   (busy),
    .done                   (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  checks = 0;
  int  errors = 0;
  bit  sb_en = 1'b0;
  int  bf = 1;
  int  bt = 0;
  ev_t q_rd[$];
  ev_t q_iv[$];
  ev_t q_mk[$];
  int  q_done[$];
  ev_t m_e;
  int  m_d;
  int  bias_arr[0:511];
  int  sum_arr[0:511];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic extra(input string nm);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d: output with nothing expected", nm, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sh(input int c, input int s0, input int l);
    return (l > 0 && c >= s0) ? c + l : c;
  endfunction

  // Monitor: compares every presented output against the head of its queue.
  always @(negedge clk) begin
    if (sb_en) begin
      chk("busy", int'(busy), int'(cyc >= bf && cyc <= bt));
      if (rd_en) begin
        if (q_rd.size() == 0) extra("rd_en");
        else begin
          m_e = q_rd.pop_front();
          chk("rd_cycle", cyc, m_e.cyc);
          chk("rd_k", int'(rd_k), m_e.a);
          chk("rd_row", int'(rd_row), m_e.b);
          chk("rd_col", int'(rd_col), m_e.c);
          chk("rd_channel", int'(rd_channel), m_e.d);
        end
      end
      if (controller_input_valid) begin
        if (q_iv.size() == 0) extra("input_valid");
        else begin
          m_e = q_iv.pop_front();
          chk("iv_cycle", cyc, m_e.cyc);
          chk("iv_mat", int'(controller_mat_size), m_e.a);
          chk("iv_row", int'(controller_pos_row), m_e.b);
          chk("iv_col", int'(controller_pos_col), m_e.c);
          chk("iv_channel", int'(controller_channel), m_e.d);
        end
      end
      if (load_bias_mask != '0 || load_sum_mask != '0) begin
        if (q_mk.size() == 0) extra("mask");
        else begin
          m_e = q_mk.pop_front();
          chk("mask_cycle", cyc, m_e.cyc);
          chk("load_bias_mask", int'(load_bias_mask), m_e.a);
          chk("load_sum_mask", int'(load_sum_mask), m_e.b);
        end
      end
      if (done) begin
        if (q_done.size() == 0) extra("done");
        else begin
          m_d = q_done.pop_front();
          chk("done_cycle", cyc, m_d);
        end
      end
    end
  end

  // Issue one layer, push its expected trace, optionally stall and
  // re-pulse start mid-layer, then run past the expected done.
  task automatic run_layer(input int mat, input int nch, input int klen,
                           input int stall_rel, input int stall_len, input int xstart_rel);
    int s, kv, tpa, ntl, last, done_rel, s0, ch, rem;
    ev_t e;
    tick();
    s = cyc;
    cfg_mat_size = COORD_W'(mat);
    cfg_num_ch   = CH_BITS'(nch);
    cfg_k_len    = KLEN_W'(klen);
    start        = 1'b1;
    s0  = s + stall_rel;
    kv  = (klen + SA_VECTOR_WIDTH - 1) / SA_VECTOR_WIDTH;
    tpa = (mat + SA_N - 1) / SA_N;
    ntl = tpa * tpa * nch;
    if (mat == 0 || nch == 0 || klen == 0) begin
      done_rel = 1;
      q_done.push_back(s + 1);
      bf = 1;
      bt = 0;
    end else begin
      for (int r = 0; r < 512; r++) begin
        bias_arr[r] = 0;
        sum_arr[r]  = 0;
      end
      for (int t = 0; t < ntl; t++) begin
        ch  = t / (tpa * tpa);
        rem = t % (tpa * tpa);
        for (int k = 0; k < kv; k++) begin
          e.cyc = sh(s + 1 + t * kv + k, s0, stall_len);
          e.a = k; e.b = (rem / tpa) * SA_N; e.c = (rem % tpa) * SA_N; e.d = ch;
          q_rd.push_back(e);
        end
        e.cyc = sh(s + 2 + t * kv, s0, stall_len);
        e.a = mat; e.b = (rem / tpa) * SA_N; e.c = (rem % tpa) * SA_N; e.d = ch;
        q_iv.push_back(e);
        for (int i = 0; i < SA_N; i++)
          for (int j = 0; j < SA_N; j++) begin
            bias_arr[2 + t * kv + i + j]      |= (1 << (i * SA_N + j));
            sum_arr[2 + t * kv + i + j + kv]  |= (1 << (i * SA_N + j));
          end
      end
      last     = 2 + (ntl - 1) * kv + kv + 2 * (SA_N - 1);
      done_rel = last + DRAIN_CYCLES;
      for (int r = 0; r <= last; r++) begin
        if (bias_arr[r] != 0 || sum_arr[r] != 0) begin
          e.cyc = sh(s + r, s0, stall_len);
          e.a = bias_arr[r]; e.b = sum_arr[r]; e.c = 0; e.d = 0;
          q_mk.push_back(e);
        end
      end
      q_done.push_back(sh(s + done_rel, s0, stall_len));
      bf = s + 1;
      bt = sh(s + done_rel, s0, stall_len) - 1;
    end
    for (int rel = 1; rel <= done_rel + stall_len + 3; rel++) begin
      tick();
      start = (rel == xstart_rel);
      if (rel == xstart_rel) begin
        cfg_mat_size = COORD_W'(4);
        cfg_num_ch   = CH_BITS'(1);
        cfg_k_len    = KLEN_W'(4);
      end
      stall = (stall_len > 0 && rel >= stall_rel && rel < stall_rel + stall_len);
    end
    stall = 1'b0;
    start = 1'b0;
    chk("rd_left", q_rd.size(), 0);
    chk("iv_left", q_iv.size(), 0);
    chk("mask_left", q_mk.size(), 0);
    chk("done_left", q_done.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_rd_k"}, int'(rd_k), 0);
    chk({tag, "_rd_row"}, int'(rd_row), 0);
    chk({tag, "_rd_col"}, int'(rd_col), 0);
    chk({tag, "_rd_channel"}, int'(rd_channel), 0);
    chk({tag, "_input_valid"}, int'(controller_input_valid), 0);
    chk({tag, "_ctrl_mat"}, int'(controller_mat_size), 0);
    chk({tag, "_ctrl_row"}, int'(controller_pos_row), 0);
    chk({tag, "_ctrl_col"}, int'(controller_pos_col), 0);
    chk({tag, "_ctrl_ch"}, int'(controller_channel), 0);
    chk({tag, "_bias_mask"}, int'(load_bias_mask), 0);
    chk({tag, "_sum_mask"}, int'(load_sum_mask), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: bench did not finish", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    sb_en = 1'b1;
    repeat (2) tick();

    // Single tile, K_VECS=1.
    run_layer(4, 1, 4, 0, 0, 0);
    // Two channels of four tiles, K_VECS=4, with an ignored start mid-layer.
    run_layer(8, 2, 16, 0, 0, 6);
    // Edge tiles, K_VECS=2.
    run_layer(6, 1, 5, 0, 0, 0);
    // Three-cycle stall in the middle of RUN.
    run_layer(8, 1, 8, 4, 3, 0);
    // Stall inside DRAIN.
    run_layer(4, 1, 8, 12, 2, 0);
    // Zero reduction length and zero channels: immediate done.
    run_layer(8, 1, 0, 0, 0, 0);
    run_layer(8, 0, 16, 0, 0, 0);

    // Abort a layer with reset while in RUN.
    sb_en = 1'b0;
    tick();
    cfg_mat_size = COORD_W'(8);
    cfg_num_ch   = CH_BITS'(2);
    cfg_k_len    = KLEN_W'(16);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("abort");
    bf = 1;
    bt = 0;
    sb_en = 1'b1;
    repeat (20) tick();
    // Full layer after the abort.
    run_layer(5, 1, 4, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
